// File: rtl/event_loader.sv
// event_loader: drains one event (WORDS words) from a standard (non-FWFT) FIFO
// into a parallel register bank, presents it until the consumer acknowledges,
// then returns to IDLE.
// Optional feature: define EVENT_LOADER_COUNT_EN to get an accepted-event
// counter on event_count_o; otherwise event_count_o is tied to zero.
// WORDS is expected to be at least 2.
module event_loader #(
  parameter int WORDS = 16,
  parameter int WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic                          empty_i,
  input  logic [WIDTH-1:0]              dout_i,
  output logic                          rd_en_o,
  output logic [WORDS-1:0][WIDTH-1:0]   event_o,
  output logic                          event_valid_o,
  input  logic                          event_ack_i,
  output logic                          busy_o,
  output logic [31:0]                   event_count_o
);

  localparam int CW = $clog2(WORDS) + 1;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, READING, PRESENT} state_t;

  state_t                      state;
  state_t                      state_next;
  logic [CW-1:0]               issued;
  logic [CW-1:0]               captured;
  logic                        pending;     // a read was strobed last cycle, data is on dout_i now
  logic                        last_capture;
  logic [WORDS-1:0][WIDTH-1:0] event_data;
  logic                        valid;

  // The word landing this cycle is the final one of the event
  assign last_capture = pending && (captured == CW'(WORDS - 1));

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and read strobe (strobe depends only on registered state/counters and empty_i)
  always_comb begin
    state_next = state;
    rd_en_o    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty_i) state_next = READING;
      end
      READING: begin
        rd_en_o = !empty_i && (issued < CW'(WORDS));
        if (last_capture) state_next = PRESENT;
      end
      PRESENT: begin
        if (event_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Issue/capture counters, cleared when a new event starts
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      issued   <= '0;
      captured <= '0;
    end else if (state == IDLE && state_next == READING) begin
      issued   <= '0;
      captured <= '0;
    end else if (state == READING) begin
      if (rd_en_o) issued   <= issued + CW'(1);
      if (pending) captured <= captured + CW'(1);
    end
  end

  // Track the one-cycle FIFO read latency; an in-flight read is dropped on reset
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pending <= 1'b0;
    end else begin
      pending <= rd_en_o;
    end
  end

  // Capture returned words into their slot; holds its value outside READING
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      event_data <= '0;
    end else if (state == READING && pending) begin
      event_data[captured[IW-1:0]] <= dout_i;
    end
  end

  // Valid rises the cycle after the last capture, falls the cycle after the handshake
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid <= 1'b0;
    end else if (state == READING && last_capture) begin
      valid <= 1'b1;
    end else if (state == PRESENT && event_ack_i) begin
      valid <= 1'b0;
    end
  end

  assign event_o       = event_data;
  assign event_valid_o = valid;
  assign busy_o        = (state != IDLE);

`ifdef EVENT_LOADER_COUNT_EN
  logic [31:0] count;

  // Count accepted events, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (state == PRESENT && event_ack_i) begin
      count <= count + 32'd1;
    end
  end

  assign event_count_o = count;
`else
  assign event_count_o = '0;
`endif

endmodule

// File: tb/tb_event_loader.sv
// tb_event_loader: table-driven scenarios, hand-written corner sequences and a
// randomized run against a FIFO model plus an in-order word scoreboard.
module tb_event_loader;

  localparam int WORDS = 16;
  localparam int WIDTH = 64;
  localparam int EVW   = WORDS * WIDTH;

  logic                        clk = 1'b0;
  logic                        aresetn = 1'b1;
  logic                        empty_i;
  logic [WIDTH-1:0]            dout_i = '0;
  logic                        rd_en_o;
  logic [WORDS-1:0][WIDTH-1:0] event_o;
  logic                        event_valid_o;
  logic                        event_ack_i = 1'b0;
  logic                        busy_o;
  logic [31:0]                 event_count_o;

  logic                        stall = 1'b1;
  logic [WIDTH-1:0]            mem [0:1023];
  int                          wr_ptr = 0;
  int                          rd_ptr = 0;
  logic [WIDTH-1:0]            exp_q [$];
  logic [31:0]                 exp_count = 0;
  int                          checks = 0;
  int                          failures = 0;

  typedef struct {
    int stall_from;
    int stall_len;
    int ack_delay;
    int early_ack;
    int extra_words;
    int exp_valid;
    int exp_width;
    int exp_reads;
  } vec_t;

  vec_t vecs [5];

  event_loader #(.WORDS(WORDS), .WIDTH(WIDTH)) dut (
    .clk           (clk),
    .aresetn       (aresetn),
    .empty_i       (empty_i),
    .dout_i        (dout_i),
    .rd_en_o       (rd_en_o),
    .event_o       (event_o),
    .event_valid_o (event_valid_o),
    .event_ack_i   (event_ack_i),
    .busy_o        (busy_o),
    .event_count_o (event_count_o)
  );

  always #5 clk = ~clk;

  // Standard FIFO model: data appears on dout_i the cycle after the read strobe
  assign empty_i = stall || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (rd_en_o && !empty_i) begin
      dout_i <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic chk(input string name, input logic [EVW-1:0] act, input logic [EVW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    mem[wr_ptr % 1024] = w;
    wr_ptr++;
    exp_q.push_back(w);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push({$urandom(), $urandom()});
  endtask

  // Compare presented event against the next WORDS words pushed, in order
  task automatic check_event(input string name);
    if (exp_q.size() < WORDS) begin
      chk({name, "_underflow"}, EVW'(exp_q.size()), EVW'(WORDS));
    end else begin
      for (int k = 0; k < WORDS; k++) begin
        chk($sformatf("%s_slot%0d", name, k), EVW'(event_o[k]), EVW'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic protocol_chk();
    chk("rd_while_empty", EVW'(rd_en_o && empty_i), EVW'(0));
  endtask

  task automatic note_handshake();
`ifdef EVENT_LOADER_COUNT_EN
    if (event_valid_o && event_ack_i) exp_count = exp_count + 32'd1;
`endif
  endtask

  // Bounded wait for event_valid_o, sampled mid-cycle
  task automatic wait_valid(input string name, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      #1;
      protocol_chk();
      if (event_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, EVW'(0), EVW'(1));
  endtask

  task automatic ack_once();
    @(negedge clk);
    event_ack_i = 1'b1;
    #1;
    note_handshake();
    @(negedge clk);
    event_ack_i = 1'b0;
    #1;
    chk("valid_drop_after_ack", EVW'(event_valid_o), EVW'(0));
  endtask

  initial begin
    logic [EVW-1:0] snap;
    int reads, first_valid, width, tot_reads, ev_done, pushed, cyc;
    bit ok, prev_valid;

    vecs[0] = '{0,  0, 0,  -1, 0,  18, 1,  16};
    vecs[1] = '{8,  5, 0,   3, 0,  23, 1,  16};
    vecs[2] = '{1,  3, 1,   2, 0,  21, 2,  16};
    vecs[3] = '{16, 2, 3,  -1, 0,  20, 4,  16};
    vecs[4] = '{0,  0, 50,  5, 16, 18, 51, 16};

    // Reset state
    #2 aresetn = 1'b0;
    #1;
    chk("rst_rd_en", EVW'(rd_en_o), EVW'(0));
    chk("rst_valid", EVW'(event_valid_o), EVW'(0));
    chk("rst_busy", EVW'(busy_o), EVW'(0));
    chk("rst_count", EVW'(event_count_o), EVW'(0));
    chk("rst_event", event_o, EVW'(0));
    repeat (3) @(negedge clk);
    aresetn = 1'b1;

    // Table-driven scenarios
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      stall = 1'b1;
      push_rand(WORDS + vecs[v].extra_words);
      event_ack_i = 1'b1;          // ack while IDLE must be ignored
      #1;
      note_handshake();
      @(negedge clk);
      event_ack_i = 1'b0;
      reads = 0;
      first_valid = -1;
      width = 0;
      snap = '0;
      for (int c = 0; c <= vecs[v].exp_valid + vecs[v].exp_width; c++) begin
        if (c > 0) @(negedge clk);
        stall = (vecs[v].stall_len > 0) && (c >= vecs[v].stall_from) &&
                (c < vecs[v].stall_from + vecs[v].stall_len);
        event_ack_i = (c == vecs[v].exp_valid + vecs[v].ack_delay) || (c == vecs[v].early_ack);
        #1;
        protocol_chk();
        note_handshake();
        if (rd_en_o) reads++;
        if (c == 0) chk($sformatf("v%0d_busy_c0", v), EVW'(busy_o), EVW'(0));
        if (c == 1) chk($sformatf("v%0d_busy_c1", v), EVW'(busy_o), EVW'(1));
        if (event_valid_o) begin
          width++;
          chk($sformatf("v%0d_rd_in_present", v), EVW'(rd_en_o), EVW'(0));
          if (first_valid < 0) begin
            first_valid = c;
            snap = event_o;
            check_event($sformatf("v%0d", v));
          end else begin
            chk($sformatf("v%0d_event_stable", v), event_o, snap);
          end
        end
      end
      event_ack_i = 1'b0;
      $display("vector %0d: valid_at=%0d width=%0d reads=%0d", v, first_valid, width, reads);
      chk($sformatf("v%0d_valid_cycle", v), EVW'(first_valid), EVW'(vecs[v].exp_valid));
      chk($sformatf("v%0d_valid_width", v), EVW'(width), EVW'(vecs[v].exp_width));
      chk($sformatf("v%0d_reads", v), EVW'(reads), EVW'(vecs[v].exp_reads));
      chk($sformatf("v%0d_retained", v), event_o, snap);
      chk($sformatf("v%0d_count", v), EVW'(event_count_o), EVW'(exp_count));
    end

    // Second event queued behind the withheld ack loads only now
    wait_valid("second_event", 60, ok);
    if (ok) begin
      check_event("second_event");
      ack_once();
    end
    chk("second_count", EVW'(event_count_o), EVW'(exp_count));
    $display("second event done count=%0d", event_count_o);

    // Reset after the 9th read discards the partial event
    @(negedge clk);
    stall = 1'b1;
    push_rand(9);
    @(negedge clk);
    stall = 1'b0;
    reads = 0;
    for (int i = 0; i < 40 && reads < 9; i++) begin
      @(negedge clk);
      #1;
      protocol_chk();
      if (rd_en_o) reads++;
    end
    chk("mid_reads", EVW'(reads), EVW'(9));
    @(negedge clk);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_rd_en", EVW'(rd_en_o), EVW'(0));
    chk("mid_rst_valid", EVW'(event_valid_o), EVW'(0));
    chk("mid_rst_busy", EVW'(busy_o), EVW'(0));
    chk("mid_rst_count", EVW'(event_count_o), EVW'(0));
    chk("mid_rst_event", event_o, EVW'(0));
    for (int i = 0; i < 9; i++) void'(exp_q.pop_front());
    exp_count = 0;
    @(negedge clk);
    aresetn = 1'b1;
    push_rand(WORDS);
    wait_valid("post_reset", 60, ok);
    if (ok) begin
      check_event("post_reset");
      ack_once();
    end
    chk("post_reset_count", EVW'(event_count_o), EVW'(exp_count));
    $display("reset-recovery event done count=%0d", event_count_o);

    // Randomized run: random FIFO stalls, pushes and stray acks
    ev_done = 0;
    pushed = 0;
    cyc = 0;
    tot_reads = 0;
    prev_valid = 1'b0;
    snap = '0;
    while (ev_done < 12 && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      stall = ($urandom_range(0, 3) == 0);
      if (pushed < 12 * WORDS && $urandom_range(0, 1) == 1) begin
        push({$urandom(), $urandom()});
        pushed++;
      end
      event_ack_i = ($urandom_range(0, 2) == 0);
      #1;
      protocol_chk();
      if (rd_en_o) tot_reads++;
      if (event_valid_o && !prev_valid) begin
        check_event($sformatf("rand%0d", ev_done));
        snap = event_o;
      end else if (event_valid_o) begin
        chk("rand_stable", event_o, snap);
      end
      note_handshake();
      if (event_valid_o && event_ack_i) begin
        ev_done++;
        $display("random event %0d accepted at cycle %0d", ev_done, cyc);
      end
      prev_valid = event_valid_o;
    end
    event_ack_i = 1'b0;
    stall = 1'b1;
    chk("rand_events", EVW'(ev_done), EVW'(12));
    chk("rand_reads", EVW'(tot_reads), EVW'(12 * WORDS));
    chk("rand_count", EVW'(event_count_o), EVW'(exp_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
